// File: rtl/ext_com_rx.sv
// ext_com_rx: receive end of the inter-board serial link.
// Deserialises start/sel[1:0]/data[7:0]/parity(even)/stop frames from a
// single-wire line, then acts as a local-bus initiator to write the byte
// to the selected slave. Counts delivered frames and framing errors.
// Optional feature macro: EXT_COM_RX_TIMEOUT_EN (grant-wait timeout).
module ext_com_rx #(
  parameter int CLKS_PER_BIT   = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic [1:0] slave_sel,
  output logic [7:0] wdata,
  output logic       wvalid,
  input  logic       slave_ack,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] rx_count,
  output logic [3:0] err_count,
  output logic [3:0] state
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  // Reject parameter values the bit timer and timeout counter cannot honour.
  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_param
    $error("ext_com_rx: illegal CLKS_PER_BIT or TIMEOUT_CYCLES");
  end

`ifdef EXT_COM_RX_TIMEOUT_EN
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_START = 4'd1, S_DATA = 4'd2, S_PARITY = 4'd3,
    S_STOP = 4'd4, S_REQ = 4'd5, S_XFER = 4'd6, S_TIMEOUT = 4'd7
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_START = 4'd1, S_DATA = 4'd2, S_PARITY = 4'd3,
    S_STOP = 4'd4, S_REQ = 4'd5, S_XFER = 4'd6
  } state_t;
`endif

  state_t        state_q, state_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rx_count_q, rx_count_d;
  logic [3:0]    err_count_q, err_count_d;
  logic          frame_err_q, frame_err_d;
  logic          tick_half, tick_full;
`ifdef EXT_COM_RX_TIMEOUT_EN
  logic [7:0]    to_cnt_q, to_cnt_d;
`endif

  // Mid-bit sample points: half a bit after the start edge, then every full bit.
  assign tick_half = (timer_q == TW'(CLKS_PER_BIT / 2 - 1));
  assign tick_full = (timer_q == TW'(CLKS_PER_BIT - 1));

  // Two-flop synchroniser plus a previous-sample flop for start-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      sel_q       <= '0;
      data_q      <= '0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      frame_err_q <= 1'b0;
`ifdef EXT_COM_RX_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      frame_err_q <= frame_err_d;
`ifdef EXT_COM_RX_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // Next-state logic: receive framing, error accounting and bus handshake.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    sel_d       = sel_q;
    data_d      = data_q;
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    frame_err_d = 1'b0;
`ifdef EXT_COM_RX_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Only a genuine high-to-low edge starts a frame.
        if (rx_prev_q && !rx_s2_q) begin
          state_d = S_START;
          timer_d = '0;
        end
      end
      S_START: begin
        if (tick_half) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick_full) begin
          timer_d   = '0;
          shift_d   = {rx_s2_q, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) state_d = S_PARITY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick_full) begin
          timer_d   = '0;
          par_err_d = ^{shift_q, rx_s2_q};
          state_d   = S_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick_full) begin
          timer_d = '0;
          if (!rx_s2_q || par_err_q) begin
            frame_err_d = 1'b1;
            if (err_count_q != 4'hF) err_count_d = err_count_q + 1'b1;
            state_d = S_IDLE;
          end else if (shift_q[1:0] == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            sel_d   = shift_q[1:0];
            data_d  = shift_q[9:2];
            state_d = S_REQ;
`ifdef EXT_COM_RX_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_REQ: begin
        if (bus_grant) begin
          state_d = S_XFER;
`ifdef EXT_COM_RX_TIMEOUT_EN
        end else if (to_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      S_XFER: begin
        // Ack has priority over a simultaneous grant withdrawal.
        if (slave_ack) begin
          rx_count_d = rx_count_q + 1'b1;
          state_d    = S_IDLE;
        end else if (!bus_grant) begin
          state_d = S_REQ;
`ifdef EXT_COM_RX_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
`ifdef EXT_COM_RX_TIMEOUT_EN
      S_TIMEOUT: begin
        frame_err_d = 1'b1;
        if (err_count_q != 4'hF) err_count_d = err_count_q + 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_req   = (state_q == S_REQ) || (state_q == S_XFER);
  assign wvalid    = (state_q == S_XFER);
  assign busy      = (state_q != S_IDLE);
  assign slave_sel = sel_q;
  assign wdata     = data_q;
  assign frame_err = frame_err_q;
  assign rx_count  = rx_count_q;
  assign err_count = err_count_q;
  assign state     = state_q;

endmodule
